gio_irq: RTL

Parametrised successor to the fixed 8-bit GPIO/status peripheral on the Wishbone bus. It provides:
- NGPO outputs with byte-lane writes and an emergency-brake safe override.
- NGPI synchronised inputs with per-pin rising/falling-edge capture, a write-1-to-clear status register and a level interrupt to the CPU.
- A parametrised free-running tick counter.

It sits beside the PWM/PPM blocks in the peripheral region and decodes its own 8-word window.

---
 rtl/gio_pkg.sv | 20 ++
 rtl/gio_edge.sv | 33 +++
 rtl/gio_irq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gio_pkg.sv
// Shared definitions for the gio_irq GPIO/interrupt peripheral: register map,
// ID constant, tick width and the Wishbone byte-lane mask helper.
package gio_pkg;

    localparam logic [2:0] GIO_OUT     = 3'd0;
    localparam logic [2:0] GIO_IN      = 3'd1;
    localparam logic [2:0] GIO_RISE_EN = 3'd2;
    localparam logic [2:0] GIO_FALL_EN = 3'd3;
    localparam logic [2:0] GIO_STAT    = 3'd4;
    localparam logic [2:0] GIO_TICK    = 3'd5;
    localparam logic [2:0] GIO_ID      = 3'd6;

    localparam logic [31:0] GIO_ID_BASE = 32'h6710_0000;
    localparam int          TICK_W      = 16;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gio_edge.sv
// One input pin: two-flop synchroniser plus a history flop, giving the
// synchronised level and single-cycle rise/fall indications.
module gio_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // synchroniser chain and history flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= pin;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign level = s2_r;
    assign rise  = s2_r & ~s3_r;
    assign fall  = ~s2_r & s3_r;

endmodule

// File: rtl/gio_irq.sv
// Wishbone GPIO peripheral: byte-lane output register with brake override,
// synchronised inputs with edge capture into a W1C status register, tick counter.
module gio_irq
    import gio_pkg::*;
#(
    parameter int          NGPO     = 8,
    parameter int          NGPI     = 8,
    parameter int          TICK_DIV = 50000,
    parameter logic [31:0] OUT_RST  = 32'h0000_0000,
    parameter logic [31:0] SAFE_VAL = 32'h0000_0000
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    input  logic            wb_cyc,
    input  logic            wb_stb,
    input  logic            wb_we,
    input  logic [3:0]      wb_sel,
    input  logic [7:0]      wb_adr,
    input  logic [31:0]     wb_dat,
    output logic [31:0]     wb_rdt,
    output logic            wb_ack,
    input  logic [NGPI-1:0] gpi,
    input  logic            ebrake,
    output logic [NGPO-1:0] q,
    output logic            irq
);

    localparam int             DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic              ack_r;
    logic              commit_s;
    logic [31:0]       mask_s;
    logic [31:0]       rdt_s;
    logic [NGPO-1:0]   out_r;
    logic [NGPO-1:0]   q_r;
    logic [NGPI-1:0]   rise_en_r;
    logic [NGPI-1:0]   fall_en_r;
    logic [NGPI-1:0]   stat_r;
    logic [NGPI-1:0]   stat_nxt_s;
    logic [NGPI-1:0]   set_s;
    logic [NGPI-1:0]   clr_s;
    logic [NGPI-1:0]   in_s;
    logic [NGPI-1:0]   rise_s;
    logic [NGPI-1:0]   fall_s;
    logic              irq_r;
    logic              wr_out_s;
    logic              wr_rise_s;
    logic              wr_fall_s;
    logic              wr_stat_s;
    logic              eb1_r;
    logic              eb_sync_r;
    logic [DIV_W-1:0]  div_r;
    logic [TICK_W-1:0] tick_r;
    logic              unused_s;

    for (genvar i = 0; i < NGPI; i++) begin : g_pin
        gio_edge u_edge (
            .clk   (wb_clk),
            .rst_n (wb_rst_n),
            .pin   (gpi[i]),
            .level (in_s[i]),
            .rise  (rise_s[i]),
            .fall  (fall_s[i])
        );
    end

    // The ack blocks a second commit, so each access writes (and W1C clears) once.
    assign commit_s   = wb_cyc & wb_stb & wb_we & ~ack_r;
    assign mask_s     = lane_mask(wb_sel);
    assign set_s      = (rise_s & rise_en_r) | (fall_s & fall_en_r);
    assign clr_s      = wr_stat_s ? (wb_dat[NGPI-1:0] & mask_s[NGPI-1:0]) : '0;
    assign stat_nxt_s = (stat_r & ~clr_s) | set_s;
    assign unused_s   = &{1'b0, wb_adr[7:5], wb_adr[1:0], wb_dat, mask_s};

    // write decoder
    always_comb begin
        wr_out_s  = 1'b0;
        wr_rise_s = 1'b0;
        wr_fall_s = 1'b0;
        wr_stat_s = 1'b0;
        if (commit_s) begin
            case (wb_adr[4:2])
                GIO_OUT:     wr_out_s  = 1'b1;
                GIO_RISE_EN: wr_rise_s = 1'b1;
                GIO_FALL_EN: wr_fall_s = 1'b1;
                GIO_STAT:    wr_stat_s = 1'b1;
                default:     wr_out_s  = 1'b0;
            endcase
        end else begin
            wr_out_s = 1'b0;
        end
    end

    // read multiplexer
    always_comb begin
        rdt_s = 32'h0000_0000;
        case (wb_adr[4:2])
            GIO_OUT:     rdt_s = 32'(out_r);
            GIO_IN:      rdt_s = 32'(in_s);
            GIO_RISE_EN: rdt_s = 32'(rise_en_r);
            GIO_FALL_EN: rdt_s = 32'(fall_en_r);
            GIO_STAT:    rdt_s = 32'(stat_r);
            GIO_TICK:    rdt_s = {eb_sync_r, 15'h0000, tick_r};
            GIO_ID:      rdt_s = GIO_ID_BASE | (32'(NGPI) << 8) | 32'(NGPO);
            default:     rdt_s = 32'h0000_0000;
        endcase
    end

    // bus handshake and software-visible registers
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_r     <= 1'b0;
            out_r     <= OUT_RST[NGPO-1:0];
            rise_en_r <= '0;
            fall_en_r <= '0;
            stat_r    <= '0;
            irq_r     <= 1'b0;
        end else begin
            ack_r <= ~ack_r & wb_cyc & wb_stb;
            if (wr_out_s) begin
                out_r <= (out_r & ~mask_s[NGPO-1:0]) | (wb_dat[NGPO-1:0] & mask_s[NGPO-1:0]);
            end
            if (wr_rise_s) begin
                rise_en_r <= (rise_en_r & ~mask_s[NGPI-1:0]) | (wb_dat[NGPI-1:0] & mask_s[NGPI-1:0]);
            end
            if (wr_fall_s) begin
                fall_en_r <= (fall_en_r & ~mask_s[NGPI-1:0]) | (wb_dat[NGPI-1:0] & mask_s[NGPI-1:0]);
            end
            stat_r <= stat_nxt_s;
            irq_r  <= |stat_nxt_s;
        end
    end

    // brake synchroniser, output pin register and tick divider
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            eb1_r     <= 1'b0;
            eb_sync_r <= 1'b0;
            q_r       <= OUT_RST[NGPO-1:0];
            div_r     <= '0;
            tick_r    <= '0;
        end else begin
            eb1_r     <= ebrake;
            eb_sync_r <= eb1_r;
            q_r       <= eb_sync_r ? SAFE_VAL[NGPO-1:0] : out_r;
            if (div_r == DIV_LAST) begin
                div_r  <= '0;
                tick_r <= tick_r + TICK_W'(1);
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    assign wb_rdt = rdt_s;
    assign wb_ack = ack_r;
    assign q      = q_r;
    assign irq    = irq_r;

endmodule
